// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush and occupancy output.
module pipe_stage_reg #(
   parameter int               WIDTH       = 64,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic [1:0]       o_occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_out_valid;
   logic             r_in_ready;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;

   logic w_in_fire;
   logic w_out_fire;

   assign w_in_fire  = i_in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & i_out_ready;

   // Handshake flags are registered alongside the state so that in_ready
   // never depends combinationally on out_ready; the skid entry absorbs
   // the one-cycle-late backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_main      <= RESET_VALUE;
         r_skid      <= RESET_VALUE;
      end else if (i_flush) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_fire) begin
                  r_main      <= i_in_data;
                  r_state     <= ONE;
                  r_out_valid <= 1'b1;
                  r_in_ready  <= 1'b1;
               end
            end
            ONE: begin
               if (w_in_fire && w_out_fire) begin
                  r_main <= i_in_data;
               end else if (w_in_fire) begin
                  r_skid     <= i_in_data;
                  r_state    <= FULL;
                  r_in_ready <= 1'b0;
               end else if (w_out_fire) begin
                  r_state     <= EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            FULL: begin
               if (w_out_fire) begin
                  r_main     <= r_skid;
                  r_state    <= ONE;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_main;
   assign o_occupancy = r_state;

endmodule
